leela_wb_master: RTL and testbench
==================================

Name: leela_wb_master

Overview:
- Wishbone classic bus initiator for the leela accelerator subsystem; the master-side counterpart of the leela register/slave blocks.
- Accepts a command (read or write, start address, beat count) on a valid/ready port.
- Executes the command as a sequence of single-word Wishbone cycles with incrementing address.
- Streams write data in and read data out; aborts on bus error or on ack timeout and reports status.

Parameters:
- LEN_W, 8, width of cmd_len; a burst is cmd_len+1 beats (1..2^LEN_W).
- TIMEOUT, 255, number of BUS cycles without ack before abort; range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1=write burst, 0=read burst
- cmd_adr  in  32  start byte address; bits[1:0] ignored and forced to 0
- cmd_len  in  LEN_W  beats minus one
- wd_valid  in  1  write data offered
- wd_ready  out  1  write data accepted when valid&ready
- wd_data  in  32  write data word
- rd_valid  out  1  read data available
- rd_ready  in  1  read data consumed when valid&ready
- rd_data  out  32  read data word
- done_o  out  1  one-cycle pulse, burst completed successfully
- err_o  out  1  one-cycle pulse, burst aborted (wb_err_i or timeout)
- wb_adr_o  out  32  bus address
- wb_dat_o  out  32  bus write data
- wb_dat_i  in  32  bus read data
- wb_we_o  out  1  bus write enable
- wb_sel_o  out  4  byte selects, constant 4'hF whenever stb is high, else 0
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  bus strobe
- wb_ack_i  in  1  slave ack; may be combinational in the same cycle as stb
- wb_err_i  in  1  slave error

Behaviour:
- Reset: state IDLE. cmd_ready=1. All other outputs 0, including rd_data, wb_adr_o, wb_dat_o, done_o and err_o.
- Reset mid-burst: cyc/stb drop at the reset edge. No done/err pulse. Any pending rd_valid is discarded.
- All outputs are registered; wb_sel_o is derived from wb_stb_o.
- FSM states: IDLE, WDATA, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch we, adr&~3 and the beat counter (cmd_len).
  - Next state is WDATA if we=1, else BUS. cyc rises on entry to BUS.
- WDATA:
  - wd_ready=1 and wb_cyc_o stays at its current value (held high after the first beat).
  - On wd_valid: latch wd_data into wb_dat_o and go to BUS next cycle. Waiting here is unbounded.
- BUS:
  - cyc=1, stb=1, we=latched value, adr=current address.
  - On ack (ack takes priority over err in the same cycle) the beat completes; stb drops next cycle.
  - Read: capture wb_dat_i into rd_data and go to RESP.
  - Write, last beat: go to IDLE, cyc=0, pulse done_o.
  - Write, not last beat: address += 4 (32-bit wrap from FFFF_FFFC to 0000_0000), counter -= 1, go to WDATA.
- BUS error or timeout:
  - On wb_err_i, or when the timeout counter reaches TIMEOUT, go to IDLE.
  - cyc and stb drop, err_o pulses, remaining beats are abandoned and no rd_valid is produced.
- Timeout counter: 16 bits, cleared on BUS entry, increments each BUS cycle without ack/err. It covers slaves that stall ack.
- RESP:
  - rd_valid=1 and cyc is held high.
  - On rd_ready: if last beat, go to IDLE with cyc=0 and pulse done_o; else address += 4, counter -= 1, go to BUS.
- Minimum latency:
  - Read beat with combinational ack and rd_ready tied high: 2 cycles.
  - Write beat with wd_valid always high: 2 cycles.
- done_o/err_o assert in the first IDLE cycle, mutually exclusive. A new command can be accepted in that same cycle.
- cmd_valid arriving while busy is ignored until IDLE; the upstream block holds it.

Decomposition:
- Shared package leela_pkg:
  - state encoding (IDLE/WDATA/BUS/RESP)
  - WB_SEL_ALL=4'hF
  - ADR_STEP=4
- Natural sub-module: leela_wb_timeout. It holds the 16-bit counter with clear/enable inputs and a TIMEOUT compare output, and is reusable by other leela masters.

Test Plan:
- Single write: cmd_we=1, adr=0x0000_0008, len=0, wd_data=0xDEAD_BEEF, slave acks combinationally -> one stb cycle with adr=0x08, dat_o=0xDEADBEEF, sel=F, we=1. done_o pulses 1 cycle later; slave reg2 reads back 0xDEADBEEF.
- Read burst: cmd_we=0, adr=0x0, len=7 on an 8-register slave preloaded with 0x10..0x17 -> addresses 0x00,0x04..0x1C. rd_data sequence 0x10..0x17, cyc continuous for the whole burst, one done_o.
- Backpressure: read burst len=2, rd_ready low for 5 cycles on beat 1 -> rd_valid and rd_data held stable, cyc held, stb low while in RESP, data order preserved.
- Timeout: slave never acks, TIMEOUT=4 -> stb high exactly 4 cycles, then cyc=stb=0, err_o pulse, no done_o, cmd_ready=1.
- Bus error plus wrap: write len=1 at adr=0xFFFF_FFFC -> beat 0 at 0xFFFFFFFC acked, beat 1 at 0x00000000. If wb_err_i is asserted on beat 1 -> err_o pulse and IDLE.
- Reset mid-burst: assert rst during BUS of beat 3 of 8 -> next cycle cyc=stb=0, rd_valid=0, no done/err; a fresh command then completes normally.

Source files
------------

// File: rtl/leela_pkg.sv
// Shared encodings and constants for the leela Wishbone masters.
package leela_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WDATA = 2'd1;
  localparam logic [1:0] ST_BUS   = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] ADR_STEP   = 32'd4;
endpackage

// File: rtl/leela_wb_timeout.sv
// Ack-stall watchdog: 16-bit counter with clear/enable.
// hit flags the enabled cycle on which the count reaches TIMEOUT.
module leela_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign hit = en && (cnt_q == 16'(TIMEOUT - 1));
endmodule

// File: rtl/leela_wb_master.sv
// Wishbone classic initiator: runs a command as single-word cycles with incrementing address.
// All outputs registered; aborts with err_o on wb_err_i or ack timeout.
module leela_wb_master
  import leela_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [31:0]      wd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);
  logic [1:0]       state_q, state_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [31:0]      wdat_q, wdat_d;
  logic [31:0]      rdat_q, rdat_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             rdv_q, rdv_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             wd_rdy_q, wd_rdy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             last_beat;
  logic             to_hit;

  assign last_beat = (beats_q == '0);

  leela_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (state_q != ST_BUS),
    .en  ((state_q == ST_BUS) && !wb_ack_i && !wb_err_i),
    .hit (to_hit)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    beats_d = beats_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr & ~32'h3;
          beats_d = cmd_len;
          state_d = cmd_we ? ST_WDATA : ST_BUS;
        end
      end
      ST_WDATA: begin
        if (wd_valid) begin
          wdat_d  = wd_data;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // ack wins over err when a slave raises both
        if (wb_ack_i) begin
          if (!we_q) begin
            rdat_d  = wb_dat_i;
            state_d = ST_RESP;
          end else if (last_beat) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            adr_d   = adr_q + ADR_STEP;
            beats_d = beats_q - LEN_W'(1);
            state_d = ST_WDATA;
          end
        end else if (wb_err_i || to_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (rd_ready) begin
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            adr_d   = adr_q + ADR_STEP;
            beats_d = beats_q - LEN_W'(1);
            state_d = ST_BUS;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // cyc stays low while waiting for the first write word, then holds across beats
    cyc_d     = (state_d == ST_BUS) || (state_d == ST_RESP) ||
                ((state_d == ST_WDATA) && cyc_q);
    stb_d     = (state_d == ST_BUS);
    rdv_d     = (state_d == ST_RESP);
    cmd_rdy_d = (state_d == ST_IDLE);
    wd_rdy_d  = (state_d == ST_WDATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      beats_q   <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      rdv_q     <= 1'b0;
      cmd_rdy_q <= 1'b1;
      wd_rdy_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      beats_q   <= beats_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      rdv_q     <= rdv_d;
      cmd_rdy_q <= cmd_rdy_d;
      wd_rdy_q  <= wd_rdy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready = cmd_rdy_q;
  assign wd_ready  = wd_rdy_q;
  assign rd_valid  = rdv_q;
  assign rd_data   = rdat_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = wdat_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_sel_o  = stb_q ? WB_SEL_ALL : 4'h0;
endmodule

// File: tb/tb_leela_wb_master.sv
// Directed bench for leela_wb_master against an 8-word behavioural Wishbone slave.
module tb_leela_wb_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_ready;
  logic        wd_valid = 1'b0, wd_ready;
  logic [31:0] wd_data = '0;
  logic        rd_valid, rd_ready = 1'b1;
  logic [31:0] rd_data;
  logic        done_o, err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic [3:0]  wb_sel_o;

  logic        ack_en = 1'b1, err_en = 1'b0, mem_init = 1'b1;
  logic [31:0] err_adr = '0;
  logic [31:0] mem [8];
  logic [31:0] exp_mem [8];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  leela_wb_master #(.LEN_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // Slave acks combinationally; error is raised on a chosen address instead of ack
  assign wb_err_i = wb_cyc_o && wb_stb_o && err_en && (wb_adr_o == err_adr);
  assign wb_ack_i = wb_cyc_o && wb_stb_o && ack_en && !wb_err_i;
  assign wb_dat_i = mem[wb_adr_o[4:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h10 + 32'(i);
    end else if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) begin
      mem[wb_adr_o[4:2]] <= wb_dat_o;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [7:0]  len;
    logic [31:0] wbase;
    int          stall_beat;
    int          stall_cyc;
    int          err_beat;
    logic        ack_en;
    int          exp_stb;
    int          exp_rd;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] exp_adr(input logic [31:0] base, input int b);
    return (base & ~32'h3) + 32'(b) * 32'd4;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int ab = 0, wb = 0, rb = 0, stb_n = 0, dn = 0, er = 0;
    int adr_bad = 0, dat_bad = 0, prot_bad = 0, stall_cnt = 0;
    bit cyc_seen = 0, fin = 0, cmd_fire, wd_fire;
    logic [31:0] hold = '0;
    logic [31:0] ea;
    ack_en  = v.ack_en;
    err_en  = (v.err_beat >= 0);
    err_adr = exp_adr(v.adr, v.err_beat);
    cmd_we = v.we; cmd_adr = v.adr; cmd_len = v.len; cmd_valid = 1'b1;
    wd_valid = v.we; wd_data = v.wbase;
    rd_ready = !(v.stall_beat == 0 && v.stall_cyc > 0);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (wb_sel_o !== (wb_stb_o ? 4'hF : 4'h0)) prot_bad++;
      if (wb_stb_o && !wb_cyc_o) prot_bad++;
      if (cyc_seen && !wb_cyc_o && !(done_o || err_o)) prot_bad++;
      if (wb_cyc_o) cyc_seen = 1;
      if (wb_stb_o) begin
        stb_n++;
        ea = exp_adr(v.adr, ab);
        if (wb_adr_o !== ea || wb_we_o !== v.we) adr_bad++;
        if (v.we && wb_dat_o !== v.wbase + 32'(ab)) dat_bad++;
        if (wb_ack_i) begin
          if (v.we) exp_mem[ea[4:2]] = v.wbase + 32'(ab);
          ab++;
        end
      end
      if (rd_valid && !rd_ready) begin
        if (stall_cnt == 0) hold = rd_data;
        else if (rd_data !== hold) prot_bad++;
        if (wb_stb_o || !wb_cyc_o) prot_bad++;
        stall_cnt++;
      end
      if (rd_valid && rd_ready) begin
        ea = exp_adr(v.adr, rb);
        if (rd_data !== exp_mem[ea[4:2]]) dat_bad++;
        rb++;
      end
      if (done_o) dn++;
      if (err_o) er++;
      if (done_o || err_o) begin
        fin = 1;
        if (!cmd_ready || wb_cyc_o || wb_stb_o || rd_valid || (done_o && err_o)) prot_bad++;
        break;
      end
      cmd_fire = cmd_valid && cmd_ready;
      wd_fire  = wd_valid && wd_ready;
      @(posedge clk);
      #1;
      if (cmd_fire) cmd_valid = 1'b0;
      if (wd_fire) begin
        wb++;
        wd_data = v.wbase + 32'(wb);
        if (wb > int'(v.len)) wd_valid = 1'b0;
      end
      rd_ready = !(v.stall_beat == rb && stall_cnt < v.stall_cyc);
    end
    cmd_valid = 1'b0; wd_valid = 1'b0; rd_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (done_o) dn++;
      if (err_o) er++;
      if (!cmd_ready || wb_cyc_o || rd_valid) prot_bad++;
    end
    if (v.stall_beat >= 0 && stall_cnt != v.stall_cyc) prot_bad++;
    check($sformatf("v%0d finished", id), 32'(fin), 32'd1);
    check($sformatf("v%0d stb_cycles", id), stb_n, v.exp_stb);
    check($sformatf("v%0d rd_beats", id), rb, v.exp_rd);
    check($sformatf("v%0d done_pulses", id), dn, v.exp_done);
    check($sformatf("v%0d err_pulses", id), er, v.exp_err);
    check($sformatf("v%0d addr_errors", id), adr_bad, 0);
    check($sformatf("v%0d data_errors", id), dat_bad, 0);
    check($sformatf("v%0d protocol_errors", id), prot_bad, 0);
  endtask

  initial begin
    int  rb;
    bit  hit;
    vec_t fresh;
    //           we    adr            len   wbase          stl  cyc err ack  stb rd dn er
    vecs[0] = '{1'b0, 32'h0000_0000, 8'd7, 32'h0,         -1, 0, -1, 1'b1, 8, 8, 1, 0};
    vecs[1] = '{1'b1, 32'h0000_0008, 8'd0, 32'hDEAD_BEEF, -1, 0, -1, 1'b1, 1, 0, 1, 0};
    vecs[2] = '{1'b0, 32'h0000_000A, 8'd0, 32'h0,         -1, 0, -1, 1'b1, 1, 1, 1, 0};
    vecs[3] = '{1'b0, 32'h0000_0000, 8'd2, 32'h0,          1, 5, -1, 1'b1, 3, 3, 1, 0};
    vecs[4] = '{1'b0, 32'h0000_0010, 8'd3, 32'h0,         -1, 0, -1, 1'b0, 4, 0, 0, 1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 8'd1, 32'hA5A5_0000, -1, 0,  1, 1'b1, 2, 0, 0, 1};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 8'd1, 32'h0,         -1, 0, -1, 1'b1, 2, 2, 1, 0};
    vecs[7] = '{1'b1, 32'h0000_0014, 8'd2, 32'h0C0F_FEE0, -1, 0, -1, 1'b1, 3, 0, 1, 0};
    vecs[8] = '{1'b0, 32'h0000_0014, 8'd2, 32'h0,          0, 2, -1, 1'b1, 3, 3, 1, 0};
    for (int i = 0; i < 8; i++) exp_mem[i] = 32'h10 + 32'(i);

    repeat (3) @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset ctrl_outputs",
          32'({wd_ready, rd_valid, done_o, err_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o}), 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    check("reset wb_adr_o", wb_adr_o, 32'd0);
    check("reset wb_dat_o", wb_dat_o, 32'd0);
    rst = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset while beat 3 of an 8-beat read is on the bus
    ack_en = 1'b1; err_en = 1'b0; rd_ready = 1'b1;
    cmd_we = 1'b0; cmd_adr = 32'h0; cmd_len = 8'd7; cmd_valid = 1'b1;
    rb = 0; hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (wb_cyc_o) cmd_valid = 1'b0;
      if (wb_stb_o && rb == 3) begin
        rst = 1'b1;
        hit = 1;
      end
      if (rd_valid && rd_ready) rb++;
    end
    check("rst_mid reached beat3", 32'(hit), 32'd1);
    @(negedge clk);
    check("rst_mid outputs_idle",
          32'({wb_cyc_o, wb_stb_o, rd_valid, done_o, err_o, cmd_ready}), 32'b000001);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid no_pulse_after", 32'({done_o, err_o, wb_cyc_o}), 32'd0);
    fresh = '{1'b0, 32'h0000_0004, 8'd1, 32'h0, -1, 0, -1, 1'b1, 2, 2, 1, 0};
    run_vec(fresh, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
